coord_bcd_conv: RTL and testbench
=================================

Name: coord_bcd_conv

Overview:
- Sequential binary-to-BCD converter for the PS/2 mouse coordinate display path.
- Sits between the mouse position tracker, which holds 0..99 X/Y counters, and the seven-segment decoder stage.
- Converts X and Y in parallel with shift-add-3 (double-dabble).
- Presents units and tens digits per axis, held stable between conversions, and buffers one pending request while busy.

Parameters:
- WIDTH, 7: binary width of pos_x/pos_y. Legal range 4..7.
- MAX_VAL, 99: saturation ceiling, the largest value displayable on two digits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- pos_x  in  WIDTH  binary X coordinate
- pos_y  in  WIDTH  binary Y coordinate
- valid  in  1  request a conversion of pos_x/pos_y
- ready  out  1  high in IDLE; a request is accepted immediately when high
- done  out  1  one-cycle pulse; outputs updated this cycle
- ovf_x  out  1  pos_x exceeded MAX_VAL and was saturated (held with digits)
- ovf_y  out  1  pos_y exceeded MAX_VAL and was saturated (held with digits)
- bcd_ed_x  out  4  X units digit
- bcd_des_x  out  4  X tens digit
- bcd_ed_y  out  4  Y units digit
- bcd_des_y  out  4  Y tens digit

Behaviour:
- Reset (synchronous, any state, including mid-conversion):
  - state=IDLE; all digits 0; done=0; ovf_x=ovf_y=0.
  - Pending flag cleared; shift counter 0.
  - ready=1 from the first cycle after rst deasserts.
- States:
  - IDLE: ready=1. valid=1 loads both shift registers and goes to SHIFT.
  - SHIFT: ready=0. Runs exactly WIDTH cycles, then goes to LOAD.
  - LOAD: ready=0. Registers the digits and ovf flags, and pulses done (registered) in the following cycle.
    - If a request is pending (or valid=1 this cycle), load it and go to SHIFT.
    - Otherwise go to IDLE.
- Load rule: an operand greater than MAX_VAL is replaced by MAX_VAL, and its ovf bit is captured alongside it.
- Shift register per axis: {tens[3:0], units[3:0], bin[WIDTH-1:0]}.
- Each SHIFT cycle:
  - Any BCD digit >= 5 gets +3.
  - Then the whole register shifts left by 1.
  - The carry out of tens is discarded; it is guaranteed 0 because the operand is <= 99.
- Latency: with valid sampled high at edge k (ready=1), done=1 and the new digits are visible after edge k+WIDTH+2. That is 9 cycles at WIDTH=7.
- Outputs: all four digits and both ovf bits change only in the cycle done is high, so the display never shows a half-updated pair.
- Buffering while busy (state != IDLE):
  - valid=1 stores pos_x/pos_y into a one-deep pending register and sets the pending flag.
  - A later valid overwrites it (latest wins). Nothing is ever dropped except superseded requests.
- LOAD with valid=1: the live inputs take priority over the pending register, and the pending flag clears.
- Back-to-back: a continuous valid yields one done every WIDTH+1 cycles.
- X and Y always convert together and share done. No independent per-axis request.

Decomposition:
- Package coord_bcd_pkg holds:
  - typedef bcd_digit_t (logic [3:0])
  - enum conv_state_t {IDLE, SHIFT, LOAD}
  - localparam BCD_MAX_VAL=99
  - localparam BCD_DIGITS=2
- Sub-module dd_axis: a one-axis double-dabble datapath (load, step, saturate, digit outputs), instantiated twice.
- The parent holds the FSM, counter, pending register and output registers.

Test Plan:
- Reset then idle: no valid for 20 cycles -> all digits 0, ovf=0, done never high, ready=1.
- Basic conversion: pos_x=42, pos_y=7, valid for 1 cycle -> after 9 cycles done=1 with des_x=4, ed_x=2, des_y=0, ed_y=7; ready returns high the next cycle.
- Boundaries: (x=0, y=99) -> 0,0 / 9,9. Then (x=127, y=100) -> X=9,9 and Y=9,9 with ovf_x=1, ovf_y=1. Then (x=55, y=10) -> ovf bits clear.
- Pending overwrite: valid (x=12, y=34), then during SHIFT valid (56, 78), then (90, 11) -> exactly two done pulses, showing 12/34 then 90/11; 56/78 never appears.
- Reset mid-operation: rst asserted in the 4th SHIFT cycle with a pending request -> digits stay at their prior reset value 0, no done, pending discarded, ready=1 after release.
- Back-to-back: valid held high with incrementing x=0..20 -> done spacing exactly 8 cycles; each output matches the value sampled at its accepting cycle.

Source files
------------

// File: rtl/coord_bcd_pkg.sv
// Shared types and constants for the mouse-coordinate BCD conversion path.
// No ports: provides digit type, converter state encoding and display limits.
package coord_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } conv_state_t;

    localparam int unsigned BCD_MAX_VAL = 99;
    localparam int unsigned BCD_DIGITS  = 2;

endpackage

// File: rtl/dd_axis.sv
// One-axis double-dabble datapath: saturating load, one shift-add-3 step per
// cycle, and the current tens/units digits read straight from the register.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture din (saturated to MAX_VAL) and clear the BCD digits
//   step      - perform one add-3-then-shift iteration
//   din       - binary operand
//   units     - units digit of the shift register
//   tens      - tens digit of the shift register
//   ovf       - din exceeded MAX_VAL at the last load
module dd_axis
    import coord_bcd_pkg::*;
#(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned MAX_VAL = BCD_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    output bcd_digit_t       units,
    output bcd_digit_t       tens,
    output logic             ovf
);

    localparam int unsigned SR_W = 4 * BCD_DIGITS + WIDTH;

    // Clamp the ceiling to what WIDTH bits can hold; narrow operands never saturate.
    localparam int unsigned SAT_I = (MAX_VAL < (2 ** WIDTH) - 1) ? MAX_VAL : (2 ** WIDTH) - 1;
    localparam logic [WIDTH-1:0] SAT = SAT_I[WIDTH-1:0];

    // Layout: {tens[3:0], units[3:0], bin[WIDTH-1:0]}
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_next;
    bcd_digit_t      units_adj;
    bcd_digit_t      tens_adj;

    always_comb begin
        units_adj = sr[WIDTH+3:WIDTH];
        tens_adj  = sr[WIDTH+7:WIDTH+4];
        if (units_adj >= 4'd5) units_adj = units_adj + 4'd3;
        if (tens_adj >= 4'd5)  tens_adj  = tens_adj + 4'd3;
        // Carry out of tens falls off the top; operand <= 99 keeps it zero.
        sr_next = {tens_adj, units_adj, sr[WIDTH-1:0]} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            if (din > SAT) begin
                sr  <= {8'h00, SAT};
                ovf <= 1'b1;
            end else begin
                sr  <= {8'h00, din};
                ovf <= 1'b0;
            end
        end else if (step) begin
            sr <= sr_next;
        end
    end

    assign units = sr[WIDTH+3:WIDTH];
    assign tens  = sr[WIDTH+7:WIDTH+4];

endmodule

// File: rtl/coord_bcd_conv.sv
// Converts the X/Y mouse coordinates to two BCD digits each for the
// seven-segment display, both axes in parallel, with a one-deep pending buffer.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   pos_x, pos_y         - binary coordinates
//   valid                - conversion request
//   ready                - high while idle (request accepted immediately)
//   done                 - one-cycle pulse when the outputs update
//   ovf_x, ovf_y         - operand was saturated to MAX_VAL
//   bcd_ed_x, bcd_des_x  - X units / tens digits
//   bcd_ed_y, bcd_des_y  - Y units / tens digits
module coord_bcd_conv
    import coord_bcd_pkg::*;
#(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned MAX_VAL = BCD_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pos_x,
    input  logic [WIDTH-1:0] pos_y,
    input  logic             valid,
    output logic             ready,
    output logic             done,
    output logic             ovf_x,
    output logic             ovf_y,
    output logic [3:0]       bcd_ed_x,
    output logic [3:0]       bcd_des_x,
    output logic [3:0]       bcd_ed_y,
    output logic [3:0]       bcd_des_y
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    conv_state_t      state;
    logic [CW-1:0]    cnt;
    logic             pend;
    logic [WIDTH-1:0] pend_x;
    logic [WIDTH-1:0] pend_y;

    // Digits are staged at LOAD and published one cycle later with done,
    // because the shift registers may already be reloaded by then.
    logic             fire;
    bcd_digit_t       stg_ed_x, stg_des_x, stg_ed_y, stg_des_y;
    logic             stg_ovf_x, stg_ovf_y;

    logic             ax_load;
    logic             ax_step;
    logic [WIDTH-1:0] ld_x;
    logic [WIDTH-1:0] ld_y;
    bcd_digit_t       ax_ed_x, ax_des_x, ax_ed_y, ax_des_y;
    logic             ax_ovf_x, ax_ovf_y;

    always_comb begin
        ax_load = ((state == IDLE) && valid) || ((state == LOAD) && (valid || pend));
        ax_step = (state == SHIFT);
        // Live inputs beat the pending register when both are present in LOAD.
        if ((state == LOAD) && !valid) begin
            ld_x = pend_x;
            ld_y = pend_y;
        end else begin
            ld_x = pos_x;
            ld_y = pos_y;
        end
    end

    dd_axis #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_axis_x (
        .clk   (clk),
        .rst   (rst),
        .load  (ax_load),
        .step  (ax_step),
        .din   (ld_x),
        .units (ax_ed_x),
        .tens  (ax_des_x),
        .ovf   (ax_ovf_x)
    );

    dd_axis #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_axis_y (
        .clk   (clk),
        .rst   (rst),
        .load  (ax_load),
        .step  (ax_step),
        .din   (ld_y),
        .units (ax_ed_y),
        .tens  (ax_des_y),
        .ovf   (ax_ovf_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            pend_x    <= '0;
            pend_y    <= '0;
            fire      <= 1'b0;
            stg_ed_x  <= '0;
            stg_des_x <= '0;
            stg_ed_y  <= '0;
            stg_des_y <= '0;
            stg_ovf_x <= 1'b0;
            stg_ovf_y <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            ovf_x     <= 1'b0;
            ovf_y     <= 1'b0;
            bcd_ed_x  <= '0;
            bcd_des_x <= '0;
            bcd_ed_y  <= '0;
            bcd_des_y <= '0;
        end else begin
            done <= fire;
            fire <= 1'b0;
            if (fire) begin
                bcd_ed_x  <= stg_ed_x;
                bcd_des_x <= stg_des_x;
                bcd_ed_y  <= stg_ed_y;
                bcd_des_y <= stg_des_y;
                ovf_x     <= stg_ovf_x;
                ovf_y     <= stg_ovf_y;
            end

            case (state)
                IDLE: begin
                    if (valid) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (valid) begin
                        pend   <= 1'b1;
                        pend_x <= pos_x;
                        pend_y <= pos_y;
                    end
                    if (cnt == LAST) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD: begin
                    stg_ed_x  <= ax_ed_x;
                    stg_des_x <= ax_des_x;
                    stg_ed_y  <= ax_ed_y;
                    stg_des_y <= ax_des_y;
                    stg_ovf_x <= ax_ovf_x;
                    stg_ovf_y <= ax_ovf_y;
                    fire      <= 1'b1;
                    pend      <= 1'b0;
                    if (valid || pend) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coord_bcd_conv.sv
module tb_coord_bcd_conv;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pos_x, pos_y;
    logic         valid;
    logic         ready, done, ovf_x, ovf_y;
    logic [3:0]   bcd_ed_x, bcd_des_x, bcd_ed_y, bcd_des_y;

    coord_bcd_conv #(.WIDTH(W), .MAX_VAL(99)) dut (
        .clk       (clk),
        .rst       (rst),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .valid     (valid),
        .ready     (ready),
        .done      (done),
        .ovf_x     (ovf_x),
        .ovf_y     (ovf_y),
        .bcd_ed_x  (bcd_ed_x),
        .bcd_des_x (bcd_des_x),
        .bcd_ed_y  (bcd_ed_y),
        .bcd_des_y (bcd_des_y)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: busy window of W+1 cycles per accepted
    // request, one-deep latest-wins buffer, result published one cycle after.
    int mcnt = 0;
    bit mpend = 0;
    int mpx = 0, mpy = 0;
    int cur_x = 0, cur_y = 0;
    bit memit = 0;
    int emit_x = 0, emit_y = 0;
    int e_ux = 0, e_tx = 0, e_uy = 0, e_ty = 0;
    bit e_ox = 0, e_oy = 0, e_done = 0, e_ready = 1;

    int cyc = 0;
    int done_cnt = 0;
    int last_done = -1;
    bit spacing_on = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    task automatic model(input bit r, input bit v, input int x, input int y);
        if (r) begin
            mcnt = 0; mpend = 0; memit = 0;
            e_ux = 0; e_tx = 0; e_uy = 0; e_ty = 0;
            e_ox = 0; e_oy = 0; e_done = 0;
        end else begin
            e_done = memit;
            if (memit) begin
                e_ux = sat(emit_x) % 10; e_tx = sat(emit_x) / 10;
                e_uy = sat(emit_y) % 10; e_ty = sat(emit_y) / 10;
                e_ox = (emit_x > 99); e_oy = (emit_y > 99);
                memit = 0;
            end
            if (mcnt == 0) begin
                if (v) begin cur_x = x; cur_y = y; mcnt = 1; end
            end else if (mcnt <= W) begin
                if (v) begin mpend = 1; mpx = x; mpy = y; end
                mcnt++;
            end else begin
                memit = 1; emit_x = cur_x; emit_y = cur_y;
                if (v) begin
                    cur_x = x; cur_y = y; mpend = 0; mcnt = 1;
                end else if (mpend) begin
                    cur_x = mpx; cur_y = mpy; mpend = 0; mcnt = 1;
                end else begin
                    mcnt = 0;
                end
            end
        end
        e_ready = (mcnt == 0);
    endtask

    task automatic cycle(input bit r, input bit v, input int x, input int y);
        rst = r; valid = v; pos_x = W'(x); pos_y = W'(y);
        @(posedge clk);
        cyc++;
        model(r, v, x, y);
        #1;
        check("done", int'(done), int'(e_done));
        check("ready", int'(ready), int'(e_ready));
        check("ed_x", int'(bcd_ed_x), e_ux);
        check("des_x", int'(bcd_des_x), e_tx);
        check("ed_y", int'(bcd_ed_y), e_uy);
        check("des_y", int'(bcd_des_y), e_ty);
        check("ovf_x", int'(ovf_x), int'(e_ox));
        check("ovf_y", int'(ovf_y), int'(e_oy));
        if (done === 1'b1) begin
            done_cnt++;
            if (spacing_on && last_done >= 0) check("spacing", cyc - last_done, W + 1);
            last_done = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic send_and_wait(input int x, input int y);
        int n;
        bit seen;
        cycle(0, 1, x, y);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(0, 0, 0, 0);
            n++;
            if (done === 1'b1) seen = 1;
        end
        check("latency", n, W + 2);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        int d0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // Idle after reset
        d0 = done_cnt;
        idle(20);
        check("idle_no_done", done_cnt - d0, 0);

        // Basic conversion and boundaries
        send_and_wait(42, 7);
        send_and_wait(0, 99);
        send_and_wait(127, 100);
        send_and_wait(55, 10);

        // Pending overwrite: 56/78 superseded by 90/11
        d0 = done_cnt;
        cycle(0, 1, 12, 34);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 56, 78);
        cycle(0, 1, 90, 11);
        idle(25);
        check("pend_done_count", done_cnt - d0, 2);

        // Reset in the 4th SHIFT cycle with a request pending
        d0 = done_cnt;
        cycle(0, 1, 20, 30);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 40, 50);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        idle(20);
        check("rst_mid_done_count", done_cnt - d0, 0);

        // Back-to-back with continuous valid
        spacing_on = 1;
        last_done = -1;
        for (int i = 0; i <= 20; i++) cycle(0, 1, i, 120 - i);
        idle(12);
        spacing_on = 0;

        // Random traffic, occasional reset
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 127)));
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
